// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops 16-bit words from a FWFT FIFO and sends each as two 8N1 bytes, low byte first.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] fifo_rdata,
    input  logic        fifo_empty,
    output logic        fifo_ren,
    output logic        tx,
    output logic        busy,
    output logic [15:0] words_sent
);
    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic          byte_sel_q, byte_sel_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   words_q, words_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          bit_end;

    assign fifo_ren   = rst_n && state_q == IDLE && en && !fifo_empty;
    assign bit_end    = timer_q == LAST;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign words_sent = words_q;

    // tx_d is the line level for the next cycle, so tx stays a clean flop output.
    // The shift register moves right once per data bit, leaving byte 1 in [7:0] after byte 0.
    always_comb begin
        state_d    = state_q;
        timer_d    = (state_q == IDLE || bit_end) ? '0 : timer_q + TW'(1);
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        words_d    = words_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        unique case (state_q)
            IDLE: if (fifo_ren) begin
                shift_d    = fifo_rdata;
                byte_sel_d = 1'b0;
                state_d    = START;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
                tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
            end
            STOP: if (bit_end) begin
                if (!byte_sel_q) begin
                    byte_sel_d = 1'b1;
                    state_d    = START;
                    tx_d       = 1'b0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    words_d = words_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_q      <= 3'd0;
            byte_sel_q <= 1'b0;
            shift_q    <= 16'd0;
            words_q    <= 16'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
            words_q    <= words_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two instances (4 and 1 clocks per bit), each checked every cycle against
// a line-level model: after a pop in cycle N, cycle N+1+j carries bit slot j/C of the 20-slot word frame.
module tb_fifo_uart_tx;
    logic clk = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    task automatic check(string nm, int c, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (C=%0d): got 0x%0h, expected 0x%0h", nm, c, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int C = (g == 0) ? 4 : 1;
        logic        rst_n = 1'b1, en = 1'b0, empty = 1'b1;
        logic        ren, tx, busy;
        logic [15:0] rdata = 16'd0, ws, w = 16'd0, wm = 16'd0;
        logic [19:0] cap = 20'd0;
        logic [15:0] q[$], dec[$];
        logic [3:0]  frm[$];
        int          pop_cyc[$];
        int          k = 0, cyc = 0, bc = 0;
        bit          done = 1'b0;

        fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
            .clk(clk), .rst_n(rst_n), .en(en), .fifo_rdata(rdata), .fifo_empty(empty),
            .fifo_ren(ren), .tx(tx), .busy(busy), .words_sent(ws)
        );

        function automatic logic line_bit(logic [15:0] wd, int j);
            int s = j / C;
            int p = s % 10;
            logic [7:0] b = (s >= 10) ? wd[15:8] : wd[7:0];
            return p == 0 ? 1'b0 : p == 9 ? 1'b1 : b[p-1];
        endfunction

        task automatic drive();
            empty = q.size() == 0;
            rdata = q.size() > 0 ? q[0] : 16'($urandom);
        endtask

        task automatic push(logic [15:0] d);
            q.push_back(d);
            drive();
        endtask

        // k = 0 when idle, else cycles since the pop (1..20*C while the word is on the line).
        task automatic step();
            logic er, et;
            bit   pop = 1'b0;
            @(negedge clk);
            if (!rst_n) begin
                k  = 0;
                wm = 16'd0;
            end
            er = rst_n && k == 0 && en && q.size() > 0;
            et = k == 0 ? 1'b1 : line_bit(w, k - 1);
            check("ren", C, 32'(ren), 32'(er));
            check("tx", C, 32'(tx), 32'(et));
            check("busy", C, 32'(busy), 32'(k != 0));
            check("words", C, 32'(ws), 32'(wm));
            if (busy) bc++;
            if (er) begin
                w   = q[0];
                pop = 1'b1;
                pop_cyc.push_back(cyc);
                k   = 1;
            end else if (k != 0) begin
                if ((k - 1) % C == C / 2) cap[(k - 1) / C] = tx;
                k++;
                if (k > 20 * C) begin
                    k = 0;
                    wm++;
                    dec.push_back({cap[18:11], cap[8:1]});
                    frm.push_back({cap[19], cap[10], cap[9], cap[0]});
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (pop) void'(q.pop_front());
            drive();
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            q.delete();
            drive();
            step();
            step();
            rst_n = 1'b1;
            pop_cyc.delete();
            dec.delete();
            frm.delete();
            bc = 0;
        endtask

        task automatic run_until(logic [15:0] n, int bound);
            for (int i = 0; i < bound && wm != n; i++) step();
            check("wait_words", C, 32'(wm), 32'(n));
        endtask

        task automatic rand_phase(int n);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0 && q.size() < 6) push(16'($urandom));
                if ($urandom_range(0, 39) == 0) en = !en;
                rst_n = $urandom_range(0, 599) != 0;
                step();
            end
            rst_n = 1'b1;
            en = 1'b1;
            for (int i = 0; i < 3000 && (q.size() > 0 || k != 0); i++) step();
            check("drain", C, 32'(q.size() + k), 32'd0);
        endtask

        if (g == 0) begin : t4
            initial begin
                #1;
                do_reset();
                check("rst_tx", C, 32'(tx), 32'd1);
                check("rst_words", C, 32'(ws), 32'd0);
                // Empty FIFO: nothing may happen.
                en = 1'b1;
                repeat (200) step();
                check("idle_pops", C, pop_cyc.size(), 0);
                check("idle_busy", C, bc, 0);
                check("idle_words", C, 32'(ws), 32'd0);
                // Single word 0xA55A.
                do_reset();
                push(16'hA55A);
                run_until(16'd1, 200);
                repeat (3) step();
                check("s1_pops", C, pop_cyc.size(), 1);
                check("s1_word", C, 32'(dec[0]), 32'hA55A);
                check("s1_frame", C, 32'(frm[0]), 32'b1010);
                check("s1_busy_cycles", C, bc, 80);
                check("s1_words", C, 32'(ws), 32'd1);
                // Three back-to-back words.
                do_reset();
                push(16'h0001);
                push(16'h8000);
                push(16'hFFFF);
                run_until(16'd3, 400);
                step();
                check("s2_pops", C, pop_cyc.size(), 3);
                check("s2_gap0", C, pop_cyc[1] - pop_cyc[0], 81);
                check("s2_gap1", C, pop_cyc[2] - pop_cyc[1], 81);
                check("s2_w0", C, 32'(dec[0]), 32'h0001);
                check("s2_w1", C, 32'(dec[1]), 32'h8000);
                check("s2_w2", C, 32'(dec[2]), 32'hFFFF);
                check("s2_words", C, 32'(ws), 32'd3);
                check("s2_busy", C, 32'(busy), 32'd0);
                // en dropped mid-word.
                do_reset();
                push(16'h1111);
                push(16'h2222);
                for (int i = 0; i < 5 && pop_cyc.size() == 0; i++) step();
                repeat (10) step();
                en = 1'b0;
                run_until(16'd1, 200);
                repeat (30) step();
                check("s4_hold", C, pop_cyc.size(), 1);
                en = 1'b1;
                step();
                check("s4_repop", C, pop_cyc.size(), 2);
                run_until(16'd2, 200);
                check("s4_w0", C, 32'(dec[0]), 32'h1111);
                check("s4_w1", C, 32'(dec[1]), 32'h2222);
                // Reset during byte 1 data.
                do_reset();
                push(16'h1234);
                push(16'h5678);
                for (int i = 0; i < 200 && k != 13 * C; i++) step();
                rst_n = 1'b0;
                #1;
                check("s5_tx", C, 32'(tx), 32'd1);
                check("s5_busy", C, 32'(busy), 32'd0);
                check("s5_ren", C, 32'(ren), 32'd0);
                check("s5_words", C, 32'(ws), 32'd0);
                step();
                step();
                rst_n = 1'b1;
                dec.delete();
                frm.delete();
                run_until(16'd1, 200);
                check("s5_next", C, 32'(dec[0]), 32'h5678);
                check("s5_frame", C, 32'(frm[0]), 32'b1010);
                rand_phase(3000);
                done = 1'b1;
            end
        end else begin : t1
            initial begin
                #1;
                do_reset();
                en = 1'b1;
                push(16'h00FF);
                push(16'h00FF);
                run_until(16'd2, 100);
                check("s6_word", C, 32'(dec[0]), 32'h00FF);
                check("s6_frame", C, 32'(frm[0]), 32'b1010);
                check("s6_gap", C, pop_cyc[1] - pop_cyc[0], 21);
                check("s6_busy_cycles", C, bc, 40);
                rand_phase(3000);
                done = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(gi[0].done && gi[1].done); i++) @(posedge clk);
        check("finish", 0, {30'd0, gi[0].done, gi[1].done}, 32'd3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drains 16-bit words from the read side of the team's 16-bit FIFO and sends each word as two 8N1 UART bytes on a single serial line.
- Sits downstream of the FIFO's rdata/ren/empty port and is the transmit-side consumer of the write-side producer.
- The FIFO read port is first-word-fall-through: rdata is valid combinationally whenever empty is low.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit; legal range 1..65535; the bit-timer width is sized from it.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  when high, new words may be popped; a word already in progress always completes
fifo_rdata  input  16  FIFO head word, valid while fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_ren  output  1  pop strobe to the FIFO, one cycle per word
tx  output  1  UART serial out; idle high
busy  output  1  high while a word is being serialised
words_sent  output  16  count of completed words, wraps at 0xFFFF->0x0000

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - tx=1, busy=0, fifo_ren=0, words_sent=0.
  - state=IDLE; shift register, byte select and bit/timer counters are cleared.
- Reset asserted mid-frame aborts the word immediately:
  - tx returns to 1 asynchronously.
  - The popped word is lost and is not counted.
- FSM states: IDLE, START, DATA, STOP.
- fifo_ren = (state==IDLE) & en & ~fifo_empty. It is combinational, asserted for exactly one cycle per word, and never asserted outside IDLE.
- IDLE:
  - On a cycle with fifo_ren=1, latch fifo_rdata into a 16-bit shift register, set byte_sel=0 and go to START.
  - Otherwise stay in IDLE.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx = current byte bit, LSB first, each bit held CLKS_PER_BIT cycles.
  - Byte 0 is word[7:0]; byte 1 is word[15:8].
  - After bit 7 go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then:
  - If byte_sel=0: set byte_sel=1 and go directly to START, with no gap between bytes of a word.
  - If byte_sel=1: increment words_sent in the cycle leaving STOP and go to IDLE.
- tx and busy are registered and change only on clock edges; tx must be glitch-free.
- Timing: if fifo_ren=1 in cycle N, tx is first low in cycle N+1.
- Word period: one word occupies 20*CLKS_PER_BIT cycles on the line, plus one IDLE cycle before the next pop. Back-to-back pops are therefore spaced 20*CLKS_PER_BIT+1 cycles apart.
- busy=1 from cycle N+1 through the last STOP cycle of byte 1; it is 0 in IDLE.
- en is sampled only in IDLE. Deasserting en mid-word has no effect until the word finishes.
- fifo_empty rising mid-word is ignored; the word is already latched.
- fifo_rdata is don't-care except in the fifo_ren cycle.
- CLKS_PER_BIT=1 is legal: each bit lasts one cycle and the word period is 21 cycles.

Test Plan:
1. Single word (CLKS_PER_BIT=4), FIFO holding 0xA55A, en=1:
   - fifo_ren pulses exactly one cycle.
   - tx sequence, 4 cycles per bit: 0, 0,1,0,1,1,0,1,0, 1 (byte 0x5A), then 0, 1,0,1,0,0,1,0,1, 1 (byte 0xA5).
   - busy high for 80 cycles, then words_sent=1.
2. Three words 0x0001, 0x8000, 0xFFFF queued:
   - fifo_ren pulses spaced exactly 81 cycles apart.
   - Decoded bytes are 01,00,00,80,FF,FF.
   - words_sent=3 and busy=0 at the end.
3. FIFO empty, en=1 for 200 cycles: fifo_ren never asserts, tx constant 1, busy=0, words_sent=0.
4. en dropped 10 cycles after a pop, with a second word queued:
   - The first word completes in full.
   - No second pop while en=0; re-asserting en pops the next word one cycle later.
5. rst_n pulled low during DATA of byte 1:
   - tx=1 and busy=0 immediately, fifo_ren=0, words_sent unchanged at 0.
   - After release with the FIFO non-empty, the next word starts from START cleanly.
6. CLKS_PER_BIT=1 with word 0x00FF:
   - Full word on tx in 20 cycles: 0,11111111,1,0,00000000,1.
   - Consecutive pops 21 cycles apart.
